// File: rtl/brcomp_pkg.sv
// Shared types for the multi-cycle branch comparator: funct3 encoding, FSM states
// and the branch decision helper.
package brcomp_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_RSV2 = 3'b010,
        BR_RSV3 = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } brcomp_state_e;

    function automatic logic br_taken(input br_op_e op, input logic lt, input logic eq);
        case (op)
            BR_BEQ:          return eq;
            BR_BNE:          return !eq;
            BR_BLT, BR_BLTU: return lt;
            BR_BGE, BR_BGEU: return !lt;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic br_illegal(input br_op_e op);
        return (op == BR_RSV2) || (op == BR_RSV3);
    endfunction

endpackage

// File: rtl/brcomp_seq_if.sv
// Request/response bundle of the branch comparator. The master side issues operands
// and consumes results; the slave side is the comparator itself.
interface brcomp_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [2:0]       br_op;
    logic             out_valid;
    logic             out_ready;
    logic             br_less;
    logic             br_equal;
    logic             br_taken;
    logic             br_illegal;

    modport master (
        output in_valid, rs1_data, rs2_data, br_op, out_ready,
        input  in_ready, out_valid, br_less, br_equal, br_taken, br_illegal
    );

    modport slave (
        input  in_valid, rs1_data, rs2_data, br_op, out_ready,
        output in_ready, out_valid, br_less, br_equal, br_taken, br_illegal
    );
endinterface

// File: rtl/brcomp_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module brcomp_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o
);
    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
endmodule

// File: rtl/brcomp_seq.sv
// Multi-cycle branch comparator, MSB chunk first, one chunk per clock.
// Define BRCOMP_EARLY_EXIT_EN to finish on the first differing chunk.
module brcomp_seq
    import brcomp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    brcomp_seq_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    brcomp_state_e    state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    br_op_e           op_reg, op_next;
    logic             lt_reg, lt_next;
    // eq_reg stays high until the first differing chunk has been seen
    logic             eq_reg, eq_next;

    logic [CHUNK-1:0] a_chunks [NCHUNK];
    logic [CHUNK-1:0] b_chunks [NCHUNK];
    logic [CW-1:0]    idx;
    logic             chk_lt;
    logic             chk_eq;
    logic             done;

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign idx = LAST - cnt_reg;

    brcomp_chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
        .a_i  (a_chunks[idx]),
        .b_i  (b_chunks[idx]),
        .lt_o (chk_lt),
        .eq_o (chk_eq)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= BR_BEQ;
            lt_reg    <= 1'b0;
            eq_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            lt_reg    <= lt_next;
            eq_reg    <= eq_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        lt_next    = lt_reg;
        eq_next    = eq_reg;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_next = BUSY;
                        cnt_next   = '0;
                        a_next     = bus.rs1_data;
                        b_next     = bus.rs2_data;
                        op_next    = br_op_e'(bus.br_op);
                        lt_next    = 1'b0;
                        eq_next    = 1'b1;
                        // Biasing the sign bits turns signed order into unsigned order
                        if (!bus.br_op[1]) begin
                            a_next[WIDTH-1] = ~bus.rs1_data[WIDTH-1];
                            b_next[WIDTH-1] = ~bus.rs2_data[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    if (eq_reg && !chk_eq) begin
                        lt_next = chk_lt;
                        eq_next = 1'b0;
                    end
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_next = DONE;
                    end
`ifdef BRCOMP_EARLY_EXIT_EN
                    if (eq_reg && !chk_eq) begin
                        state_next = DONE;
                    end
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign done           = (state_reg == DONE);
    assign bus.in_ready   = (state_reg == IDLE);
    assign bus.out_valid  = done;
    assign bus.br_less    = done & lt_reg;
    assign bus.br_equal   = done & eq_reg;
    assign bus.br_taken   = done & br_taken(op_reg, lt_reg, eq_reg);
    assign bus.br_illegal = done & br_illegal(op_reg);

endmodule

// File: tb/tb_brcomp_seq.sv
// Scoreboard bench for brcomp_seq (WIDTH=32, CHUNK=8); latency expectations follow
// BRCOMP_EARLY_EXIT_EN when it is defined for the build.
module tb_brcomp_seq;

    typedef struct {
        logic less;
        logic equal;
        logic taken;
        logic illegal;
        int   lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    brcomp_seq_if #(.WIDTH(32)) bus ();

    brcomp_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef BRCOMP_EARLY_EXIT_EN
        for (int k = 0; k < 4; k++) begin
            if (a[31-8*k -: 8] != b[31-8*k -: 8]) return k + 1;
        end
        return 4;
`else
        return 4;
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input int stall);
        exp_t e;
        exp_t g;
        int   edges;
        bit   seen;
        e.less    = op[1] ? (a < b) : ($signed(a) < $signed(b));
        e.equal   = (a == b);
        e.illegal = (op == 3'b010) || (op == 3'b011);
        case (op)
            3'b000:         e.taken = e.equal;
            3'b001:         e.taken = !e.equal;
            3'b100, 3'b110: e.taken = e.less;
            3'b101, 3'b111: e.taken = !e.less;
            default:        e.taken = 1'b0;
        endcase
        e.lat = exp_lat(a, b);
        sb_q.push_back(e);

        check("accept_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.br_op    = op;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges = 0;
        seen  = 0;
        while (!seen && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (bus.out_valid) seen = 1;
        end
        check("out_valid_seen", 32'(seen), 1);
        g = sb_q.pop_front();
        if (seen) begin
            $display("txn op=%0b a=%08h b=%08h lat=%0d less=%0b eq=%0b taken=%0b ill=%0b",
                     op, a, b, edges, bus.br_less, bus.br_equal, bus.br_taken, bus.br_illegal);
            check("latency", edges, g.lat);
            check("less", bus.br_less, g.less);
            check("equal", bus.br_equal, g.equal);
            check("taken", bus.br_taken, g.taken);
            check("illegal", bus.br_illegal, g.illegal);
            check("done_in_ready", bus.in_ready, 0);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                check("hold_valid", bus.out_valid, 1);
                check("hold_less", bus.br_less, g.less);
                check("hold_equal", bus.br_equal, g.equal);
                check("hold_taken", bus.br_taken, g.taken);
                check("hold_in_ready", bus.in_ready, 0);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check("drop_valid", bus.out_valid, 0);
            check("drop_taken", bus.br_taken, 0);
            check("idle_ready", bus.in_ready, 1);
        end
    endtask

    // Abort an op in its second BUSY cycle with either flush or reset
    task automatic abort_op(input bit use_rst);
        check("abort_accept_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.rs1_data = 32'hCAFE0001;
        bus.rs2_data = 32'hCAFE0001;
        bus.br_op    = 3'b000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", bus.in_ready, 0);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check(use_rst ? "rst_in_ready" : "flush_in_ready", bus.in_ready, 1);
        for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            check(use_rst ? "rst_no_valid" : "flush_no_valid", bus.out_valid, 0);
        end
        $display("txn abort via %s", use_rst ? "rst" : "flush");
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.br_op     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_less", bus.br_less, 0);
        check("rst_equal", bus.br_equal, 0);
        check("rst_taken", bus.br_taken, 0);
        check("rst_illegal", bus.br_illegal, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'h12345678, 32'h12345678, 3'b000, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b100, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b111, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b110, 0);
        run_op(32'h00000100, 32'h00000200, 3'b001, 0);
        run_op(32'h80000000, 32'h7FFFFFFF, 3'b101, 5);
        run_op(32'hFFFFFFFE, 32'hFFFFFFFF, 3'b100, 0);
        run_op(32'h00000010, 32'h0000000F, 3'b101, 0);
        run_op(32'h00AB0000, 32'h00AA0000, 3'b110, 0);
        run_op(32'h11111111, 32'h22222222, 3'b010, 0);
        run_op(32'h55555555, 32'h55555555, 3'b011, 0);
        abort_op(1'b0);
        run_op(32'h7FFFFFFF, 32'h80000000, 3'b100, 0);
        abort_op(1'b1);
        for (int i = 0; i < 8; i++) begin
            ra  = $urandom;
            rb  = (i % 2 == 0) ? {ra[31:8], 8'($urandom)} : $urandom;
            rop = 3'($urandom_range(0, 7));
            run_op(ra, rb, rop, i % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
